// File: rtl/enc_pkg.sv
// Shared widths and types for the 8-to-3 encoder block.
package enc_pkg;
   localparam int ENC_N_IN  = 8;
   localparam int ENC_N_OUT = 3;

   typedef logic [7:0] onehot8_t;
   typedef logic [2:0] code3_t;
endpackage

// File: rtl/enc8to3_core.sv
// Combinational priority encoder: highest set bit wins, plus any/multi flags.
module enc8to3_core
   import enc_pkg::*;
(
   input  onehot8_t x,
   output code3_t   code,
   output logic     any,
   output logic     multi
);

   logic [3:0] ones;

   always_comb begin
      code = '0;
      ones = '0;
      // Ascending scan so the last hit, the highest index, is the one kept.
      for (int i = 0; i < ENC_N_IN; i++) begin
         if (x[i]) begin
            code = code3_t'(i);
            ones = ones + 4'd1;
         end
      end
      any   = (x != '0);
      multi = (ones > 4'd1);
   end

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags, 1-cycle latency.
module encoder_8to3
   import enc_pkg::*;
#(
   parameter int N_IN  = ENC_N_IN,
   parameter int N_OUT = ENC_N_OUT
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  x,
   output logic [N_OUT-1:0] y,
   output logic             valid,
   output logic             multi_hot
);

   code3_t code_p0;
   logic   any_p0;
   logic   multi_p0;

   code3_t y_p1;
   logic   vld_p1;
   logic   multi_p1;

   enc8to3_core u_core (
      .x     (onehot8_t'(x)),
      .code  (code_p0),
      .any   (any_p0),
      .multi (multi_p0)
   );

   // p0 -> p1: the only state in the block; reset clears the code too so idle reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_p1     <= '0;
         vld_p1   <= 1'b0;
         multi_p1 <= 1'b0;
      end else begin
         y_p1     <= code_p0;
         vld_p1   <= any_p0;
         multi_p1 <= multi_p0;
      end
   end

   assign y         = N_OUT'(y_p1);
   assign valid     = vld_p1;
   assign multi_hot = multi_p1;

endmodule

// File: tb/tb_encoder_8to3.sv
// Randomised and directed bench for encoder_8to3 against a log2/popcount reference.
module tb_encoder_8to3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] x;
   logic [2:0] y;
   logic       valid;
   logic       multi_hot;

   int total = 0;
   int bad   = 0;

   logic       mdl_known = 1'b0;
   logic [2:0] mdl_y;
   logic       mdl_valid;
   logic       mdl_multi;

   encoder_8to3 dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .y         (y),
      .valid     (valid),
      .multi_hot (multi_hot)
   );

   always #5 clk = ~clk;

   function automatic int floor_log2(input int v);
      int n = 0;
      while (v > 1) begin
         v = v / 2;
         n++;
      end
      return n;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, want);
      end
   endtask

   // Reference: what the outputs must show after the edge that samples x/rst.
   always @(posedge clk) begin
      if (rst) begin
         mdl_y     = 3'd0;
         mdl_valid = 1'b0;
         mdl_multi = 1'b0;
      end else begin
         mdl_y     = (x == 8'd0) ? 3'd0 : 3'(floor_log2(int'(x)));
         mdl_valid = (x != 8'd0);
         mdl_multi = ($countones(x) >= 2);
      end
      mdl_known = 1'b1;
   end

   always @(negedge clk) begin
      if (mdl_known) begin
         chk("cyc_y", int'(y), int'(mdl_y));
         chk("cyc_valid", int'(valid), int'(mdl_valid));
         chk("cyc_multi", int'(multi_hot), int'(mdl_multi));
      end
   end

   task automatic step(input logic [7:0] xv, input logic r);
      x   = xv;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input int ey, input int ev, input int em);
      chk({name, "_y"}, int'(y), ey);
      chk({name, "_valid"}, int'(valid), ev);
      chk({name, "_multi"}, int'(multi_hot), em);
   endtask

   logic [7:0] sweep [8];

   initial begin
      rst = 1'b1;
      x   = 8'h00;
      for (int i = 0; i < 8; i++) sweep[i] = 8'(1 << i);

      // Reset held two cycles with all inputs high.
      step(8'hFF, 1'b1);
      expect_out("rst0", 0, 0, 0);
      step(8'hFF, 1'b1);
      expect_out("rst1", 0, 0, 0);
      step(8'hFF, 1'b0);
      expect_out("rel", 7, 1, 1);

      for (int i = 0; i < 8; i++) begin
         step(sweep[i], 1'b0);
         expect_out("sweep", i, 1, 0);
      end

      step(8'h00, 1'b0);
      expect_out("zero", 0, 0, 0);

      step(8'b0010_0100, 1'b0);
      expect_out("prio24", 5, 1, 1);
      step(8'b1000_0001, 1'b0);
      expect_out("prio81", 7, 1, 1);
      step(8'b0000_0011, 1'b0);
      expect_out("prio03", 1, 1, 1);

      // Sweep with a one-cycle reset landing on x=10.
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            step(sweep[i], 1'b1);
            expect_out("midrst", 0, 0, 0);
         end else begin
            step(sweep[i], 1'b0);
            expect_out("resume", i, 1, 0);
         end
      end

      for (int n = 0; n < 400; n++) begin
         logic [7:0] rv;
         case ($urandom_range(0, 3))
            0:       rv = 8'(1 << $urandom_range(0, 7));
            1:       rv = 8'h00;
            default: rv = 8'($urandom);
         endcase
         step(rv, ($urandom_range(0, 31) == 0));
      end

      step(8'h00, 1'b0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- Registered 8-to-3 binary encoder: converts an 8-bit one-hot input into the 3-bit index of the asserted bit.
- Output is registered, with one clock cycle of latency.
- Priority resolution handles non-one-hot inputs deterministically.
- Adds a valid flag and a multi-hot error flag so downstream logic can qualify the code.

Parameters:
- N_IN, 8, number of input request lines. Fixed at 8 for this block; kept only for readability.
- N_OUT, 3, output code width, equal to clog2(N_IN).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
- x  input  8  one-hot request vector; bit i asserted means code i.
- y  output  3  registered binary index of the highest set bit of x.
- valid  output  1  registered; 1 when x had at least one bit set.
- multi_hot  output  1  registered; 1 when x had two or more bits set.

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: y=3'b000, valid=0, multi_hot=0.
  - Reset overrides any input and is effective from the next edge onward.
  - Reset mid-stream discards the pending x sample.
- Encoding:
  - Combinational priority encode of x, highest index wins.
  - x[7] gives 3'd7, x[6] gives 3'd6, and so on down to x[0] giving 3'd0.
- One-hot mapping (exact):
  - 00000001→000, 00000010→001, 00000100→010, 00001000→011.
  - 00010000→100, 00100000→101, 01000000→110, 10000000→111.
- Latency: 1 cycle. Outputs reflect the x sampled at the previous rising edge. No combinational path from x to any output.
- Zero input: x=0 gives y=3'b000, valid=0, multi_hot=0.
- Multi-hot input:
  - y = index of highest set bit; valid=1; multi_hot=1.
  - Example: x=8'b00100100 gives y=101, valid=1, multi_hot=1.
- Exactly one bit set gives multi_hot=0.
- No handshake and no stall: a new x is accepted every cycle, and outputs update every cycle.
- No internal state other than the three output registers.
- No X-propagation tolerance is required; x is assumed driven after reset.

Decomposition:
- Shared package enc_pkg:
  - localparam ENC_N_IN=8, ENC_N_OUT=3.
  - typedef logic [7:0] onehot8_t.
  - typedef logic [2:0] code3_t.
- One sub-module, enc8to3_core: purely combinational.
  - Inputs: x.
  - Outputs: code, any (x != 0), multi (popcount(x) > 1).
- Top-level encoder_8to3 instantiates enc8to3_core and registers its three outputs with synchronous active-high reset.

Test Plan:
- Reset: assert rst for 2 cycles with x=8'hFF → y=000, valid=0, multi_hot=0 on both cycles. Release rst → next cycle y=111, valid=1, multi_hot=1.
- One-hot sweep: apply x=01,02,04,08,10,20,40,80 (hex), one per cycle → one cycle later y=000,001,010,011,100,101,110,111 respectively, valid=1, multi_hot=0 each.
- Zero input: x=8'h00 → next cycle y=000, valid=0, multi_hot=0.
- Priority: x=8'b00100100 → y=101, multi_hot=1. x=8'b10000001 → y=111, multi_hot=1. x=8'b00000011 → y=001, multi_hot=1.
- Latency check: change x every cycle across the sweep → each output value equals the encoding of the x from exactly one edge earlier, with no combinational glitch reaching y.
- Mid-stream reset: during the sweep, assert rst for one cycle at x=8'h10 → that cycle's output is 000/0/0, and the sweep resumes correctly after release.
